// File: rtl/sar_ctrl.sv
// Successive-approximation controller: samples the top plate, then runs an MSB-first binary
// search on the capacitive DAC bottom plates and returns the code on a valid/ready port.
module sar_ctrl #(
  parameter int unsigned NBITS         = 16,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             samp_en,
  output logic             comp_en,
  input  logic             comp_out,
  output logic [15:0]      cap_botplate_m,
  output logic [15:0]      cap_botplate_d,
  output logic [NBITS-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int unsigned CntMax = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES
                                                                    : SETTLE_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] SampleInit = CntW'(SAMPLE_CYCLES - 1);
  localparam logic [CntW-1:0] SettleInit = CntW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]      TopIdx     = 4'(NBITS - 1);
  localparam logic [15:0]     TopMask    = 16'd1 << TopIdx;

  typedef enum logic [2:0] {
    StIdle,
    StSample,
    StSettle,
    StComp,
    StDecide,
    StDone
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      bit_idx_q;

  logic [15:0] trial_mask;
  logic [15:0] next_mask;
  logic [15:0] m_decided;
  logic [15:0] m_after;

  // Resolve the current trial bit and, unless it was the LSB, raise the next trial bit.
  always_comb begin
    trial_mask = 16'd1 << bit_idx_q;
    next_mask  = trial_mask >> 1;
    m_decided  = comp_out ? cap_botplate_m : (cap_botplate_m & ~trial_mask);
    m_after    = (bit_idx_q == 4'd0) ? m_decided : (m_decided | next_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      bit_idx_q      <= TopIdx;
      busy           <= 1'b0;
      samp_en        <= 1'b0;
      comp_en        <= 1'b0;
      cap_botplate_m <= '0;
      cap_botplate_d <= '1;
      result         <= '0;
      result_valid   <= 1'b0;
    end else if (abort && (state_q != StIdle)) begin
      // Abort discards the conversion in flight; the last delivered result is kept.
      state_q        <= StIdle;
      busy           <= 1'b0;
      samp_en        <= 1'b0;
      comp_en        <= 1'b0;
      cap_botplate_m <= '0;
      cap_botplate_d <= '1;
      result_valid   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q        <= StSample;
            cnt_q          <= SampleInit;
            bit_idx_q      <= TopIdx;
            busy           <= 1'b1;
            samp_en        <= 1'b1;
            cap_botplate_m <= '0;
            cap_botplate_d <= '1;
          end
        end

        StSample: begin
          if (cnt_q == '0) begin
            state_q        <= StSettle;
            cnt_q          <= SettleInit;
            samp_en        <= 1'b0;
            cap_botplate_m <= TopMask;
            cap_botplate_d <= ~TopMask;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StSettle: begin
          if (cnt_q == '0) begin
            state_q <= StComp;
            comp_en <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StComp: begin
          state_q <= StDecide;
          comp_en <= 1'b0;
        end

        StDecide: begin
          cap_botplate_m <= m_after;
          cap_botplate_d <= ~m_after;
          if (bit_idx_q == 4'd0) begin
            state_q      <= StDone;
            result       <= m_decided[NBITS-1:0];
            result_valid <= 1'b1;
          end else begin
            state_q   <= StSettle;
            cnt_q     <= SettleInit;
            bit_idx_q <= bit_idx_q - 1'b1;
          end
        end

        StDone: begin
          if (result_ready) begin
            state_q        <= StIdle;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            cap_botplate_m <= '0;
            cap_botplate_d <= '1;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl: a default instance and an NBITS=8/SETTLE_CYCLES=3 instance,
// each driven by an ideal comparator; expected codes go through a scoreboard queue.
module tb_sar_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default instance
  logic        a_start, a_abort, a_busy, a_samp_en, a_comp_en, a_comp_out, a_valid, a_ready;
  logic [15:0] a_m, a_d, a_result, a_vin;
  logic [1:0]  a_mode;
  int          a_comp_cnt = 0;

  // Narrow instance
  logic        b_start, b_abort, b_busy, b_samp_en, b_comp_en, b_comp_out, b_valid, b_ready;
  logic [15:0] b_m, b_d;
  logic [7:0]  b_result, b_vin;
  int          b_comp_cnt = 0;

  logic [15:0] sb_q[$];

  // Ideal comparator keeps a trial bit while the DAC code does not exceed the input.
  // Mode 1 forces "drop", mode 2 forces "keep".
  assign a_comp_out = (a_mode == 2'd0) ? (a_m <= a_vin) : (a_mode == 2'd2);
  assign b_comp_out = (b_m[7:0] <= b_vin);

  sar_ctrl u_dut_a (
    .clk            (clk),
    .rst            (rst),
    .start          (a_start),
    .abort          (a_abort),
    .busy           (a_busy),
    .samp_en        (a_samp_en),
    .comp_en        (a_comp_en),
    .comp_out       (a_comp_out),
    .cap_botplate_m (a_m),
    .cap_botplate_d (a_d),
    .result         (a_result),
    .result_valid   (a_valid),
    .result_ready   (a_ready)
  );

  sar_ctrl #(
    .NBITS         (8),
    .SAMPLE_CYCLES (2),
    .SETTLE_CYCLES (3)
  ) u_dut_b (
    .clk            (clk),
    .rst            (rst),
    .start          (b_start),
    .abort          (b_abort),
    .busy           (b_busy),
    .samp_en        (b_samp_en),
    .comp_en        (b_comp_en),
    .comp_out       (b_comp_out),
    .cap_botplate_m (b_m),
    .cap_botplate_d (b_d),
    .result         (b_result),
    .result_valid   (b_valid),
    .result_ready   (b_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle plate invariants and comparator strobe counting.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_comp_en) a_comp_cnt++;
      if (b_comp_en) b_comp_cnt++;
      if (!a_samp_en) begin
        checks++;
        assert (a_d === ~a_m) else begin
          errors++;
          $error("FAIL a_d_inv: observed=%h expected=%h", a_d, ~a_m);
        end
      end
      if (!b_samp_en) begin
        checks++;
        assert (b_d === ~b_m) else begin
          errors++;
          $error("FAIL b_d_inv: observed=%h expected=%h", b_d, ~b_m);
        end
      end
      checks++;
      assert ({b_m[15:8], b_d[15:8]} === 16'h00FF) else begin
        errors++;
        $error("FAIL b_upper_lines: observed=%h expected=00ff", {b_m[15:8], b_d[15:8]});
      end
    end
  end

  // Full conversion on the default instance, expecting the result in cycle 51.
  task automatic run_a(input logic [15:0] vin, input logic [1:0] mode, input logic [15:0] exp,
                       input logic hold_ready, input string tag);
    int n;
    logic [15:0] want;
    @(negedge clk);
    a_vin   = vin;
    a_mode  = mode;
    a_ready = hold_ready;
    a_start = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    a_start    = 1'b0;
    a_comp_cnt = 0;
    n = 0;
    while (!a_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, n + 1, 51);
    check({tag, " comp_en pulses"}, a_comp_cnt, 16);
    want = sb_q.pop_front();
    check({tag, " result"}, a_result, want);
    check({tag, " busy in done"}, a_busy, 1);
    if (!hold_ready) begin
      @(negedge clk);
      a_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, " valid drop"}, a_valid, 0);
    check({tag, " idle busy"}, a_busy, 0);
    check({tag, " idle m"}, a_m, 16'h0000);
    @(negedge clk);
    a_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic seen_valid;
    logic [15:0] want;

    rst = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b0; a_vin = '0; a_mode = 2'd0;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b0; b_vin = '0;
    #2;
    check("reset busy", a_busy, 0);
    check("reset samp_en", a_samp_en, 0);
    check("reset comp_en", a_comp_en, 0);
    check("reset valid", a_valid, 0);
    check("reset m", a_m, 16'h0000);
    check("reset d", a_d, 16'hFFFF);
    check("reset result", a_result, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Ideal comparator, then stuck-low and stuck-high decisions
    run_a(16'hA5C3, 2'd0, 16'hA5C3, 1'b0, "model A5C3");
    run_a(16'h1234, 2'd1, 16'h0000, 1'b0, "stuck0");
    run_a(16'h1234, 2'd2, 16'hFFFF, 1'b1, "stuck1 one-cycle valid");

    // Narrow instance: 8 bits, 3 settle cycles, result in cycle 43
    @(negedge clk);
    b_vin   = 8'h3C;
    b_start = 1'b1;
    sb_q.push_back(16'h003C);
    @(posedge clk);
    #1;
    b_start    = 1'b0;
    b_comp_cnt = 0;
    n = 0;
    while (!b_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("nbits8 latency", n + 1, 43);
    check("nbits8 comp_en pulses", b_comp_cnt, 8);
    want = sb_q.pop_front();
    check("nbits8 result", {8'h00, b_result}, want);
    check("nbits8 busy", b_busy, 1);
    @(negedge clk);
    b_ready = 1'b1;
    @(posedge clk);
    #1;
    check("nbits8 valid drop", b_valid, 0);
    @(negedge clk);
    b_ready = 1'b0;

    // Backpressure in DONE with a stray start
    @(negedge clk);
    a_vin   = 16'h1234;
    a_mode  = 2'd0;
    a_start = 1'b1;
    sb_q.push_back(16'h1234);
    @(posedge clk);
    #1;
    a_start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("bp valid at 51", a_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a_start = (k == 3);
      @(posedge clk);
      #1;
      check("bp valid held", a_valid, 1);
      check("bp result stable", a_result, 16'h1234);
      check("bp no resample", a_samp_en, 0);
    end
    @(negedge clk);
    a_start = 1'b0;
    a_ready = 1'b1;
    want = sb_q.pop_front();
    check("bp result", a_result, want);
    @(posedge clk);
    #1;
    check("bp valid drop", a_valid, 0);
    check("bp idle", a_busy, 0);
    check("bp result kept", a_result, 16'h1234);
    @(negedge clk);
    a_ready = 1'b0;
    @(posedge clk);
    #1;
    check("bp no new conversion", a_busy, 0);

    // Abort sampled at edge 20
    @(negedge clk);
    a_vin   = 16'hBEEF;
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    a_abort = 1'b1;
    @(posedge clk);
    #1;
    a_abort = 1'b0;
    check("abort busy", a_busy, 0);
    check("abort m", a_m, 16'h0000);
    check("abort d", a_d, 16'hFFFF);
    check("abort valid", a_valid, 0);
    check("abort comp_en", a_comp_en, 0);
    check("abort result kept", a_result, 16'h1234);
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen_valid |= a_valid;
    end
    check("abort no valid", seen_valid, 0);
    run_a(16'h0F0F, 2'd0, 16'h0F0F, 1'b0, "post-abort");

    // Asynchronous reset in the SETTLE of the second bit
    @(negedge clk);
    a_vin   = 16'h5555;
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst busy", a_busy, 0);
    check("rst samp_en", a_samp_en, 0);
    check("rst comp_en", a_comp_en, 0);
    check("rst valid", a_valid, 0);
    check("rst m", a_m, 16'h0000);
    check("rst d", a_d, 16'hFFFF);
    check("rst result", a_result, 16'h0000);
    check("rst b result", {8'h00, b_result}, 16'h0000);
    #1;
    rst = 1'b0;

    run_a(16'h8001, 2'd0, 16'h8001, 1'b0, "post-reset");
    check("scoreboard empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=no finish expected=finish");
    $fatal(1, "timeout");
  end

endmodule
